squeeze_out: RTL and testbench
==============================

SQUEEZE_OUT -- requirements
Module: squeeze_out

Interface
REQ-001 Parameter: CNT_W, default 8, width of the emitted-block counter.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clock_i  input  1  rising-edge system clock.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 state_i  input  type_state (5x64)  current permutation state from ascon_pack.
REQ-006 key_i  input  128  session key; [127:64] is the high half.
REQ-007 cap_block_i  input  1  capture request for a ciphertext word, taken from state_i[0].
REQ-008 cap_tag_i  input  1  capture request for the 128-bit tag.
REQ-009 cap_rdy_o  output  1  high when a capture request will be accepted.
REQ-010 cap_err_o  output  1  one-cycle pulse when a capture request is dropped.
REQ-011 data_o  output  64  output word.
REQ-012 data_valid_o  output  1  data_o is valid.
REQ-013 data_ready_i  input  1  downstream accepts data_o.
REQ-014 data_kind_o  output  1  0 = ciphertext word, 1 = tag word.
REQ-015 data_last_o  output  1  current word is the final tag word.
REQ-016 block_cnt_o  output  CNT_W  number of ciphertext words handed off in the current message.

Function
REQ-017 FSM states: IDLE, BLOCK, TAG_HI, TAG_LO.
REQ-018 cap_rdy_o shall be 1 only in IDLE.
REQ-019 In IDLE with cap_block_i=1 and cap_tag_i=0:
- register data_o <= state_i[0];
- next state BLOCK.
REQ-020 In IDLE with cap_tag_i=1:
- register hi word state_i[3]^key_i[127:64] into data_o;
- register lo word state_i[4]^key_i[63:0] into an internal buffer;
- next state TAG_HI.
REQ-021 cap_block_i and cap_tag_i both high in IDLE: tag capture wins, block request is discarded, cap_err_o pulses next cycle.
REQ-022 Any capture request while cap_rdy_o=0 shall be ignored, with cap_err_o pulsing the next cycle; internal state is unchanged.
REQ-023 Latency: capture in cycle N shall give data_valid_o=1 in cycle N+1.
REQ-024 data_valid_o=1 in BLOCK, TAG_HI and TAG_LO; 0 in IDLE.
REQ-025 Handshake = data_valid_o & data_ready_i at a rising edge.
REQ-026 While data_valid_o=1 and data_ready_i=0, data_o, data_kind_o and data_last_o shall hold stable.
REQ-027 data_ready_i may be high with valid low; this has no effect.
REQ-028 BLOCK:
- data_kind_o=0, data_last_o=0;
- on handshake, block_cnt_o increments and FSM goes to IDLE.
REQ-029 TAG_HI:
- data_kind_o=1, data_last_o=0;
- on handshake, data_o <= buffered lo word and FSM goes to TAG_LO.
REQ-030 TAG_LO:
- data_kind_o=1, data_last_o=1;
- on handshake, FSM goes to IDLE and block_cnt_o clears to 0.
REQ-031 block_cnt_o shall wrap from 2^CNT_W-1 to 0 without error indication.
REQ-032 state_i and key_i are sampled only in the capture cycle; later changes shall not affect emitted words.
REQ-033 Minimum throughput: one ciphertext word per 2 cycles (capture, handshake); tag emission takes at least 3 cycles.
REQ-034 IDLE outputs: data_kind_o=0, data_last_o=0; data_o holds the last emitted value.

Reset
REQ-035 reset_i=1 shall force, asynchronously and independent of clock_i:
- FSM to IDLE;
- data_o=0, tag buffer=0;
- data_valid_o=0, data_kind_o=0, data_last_o=0;
- cap_err_o=0, block_cnt_o=0.
REQ-036 cap_rdy_o shall be 1 while reset is held.
REQ-037 Reset asserted mid-transfer (BLOCK/TAG_HI/TAG_LO) shall abandon the pending word; no handshake completes for it.
REQ-038 After reset deassertion, the first rising edge shall already accept a capture.

Verification
REQ-039 Block path: state_i[0]=64'h0123456789ABCDEF, cap_block_i pulse, data_ready_i=1 -> next cycle data_o=64'h0123456789ABCDEF, kind=0, last=0; handshake; block_cnt_o=1; back to IDLE.
REQ-040 Tag path:
- stimulus: state_i[3]=64'hFFFF0000FFFF0000, state_i[4]=64'h1, key_i=128'hFFFF0000FFFF0000_0000000000000003, cap_tag_i pulse;
- response: words 64'h0 (kind=1, last=0) then 64'h2 (kind=1, last=1); block_cnt_o=0 afterwards.
REQ-041 Backpressure: data_ready_i=0 for 5 cycles after a block capture, state_i changed each cycle -> data_o, kind, last unchanged; cap_block_i during the stall gives a cap_err_o pulse; a single handshake follows once ready rises.
REQ-042 Collision: cap_block_i=cap_tag_i=1 in IDLE -> tag sequence emitted, cap_err_o=1 for exactly one cycle, block_cnt_o unchanged.
REQ-043 Wrap: CNT_W=2, five ciphertext handshakes -> block_cnt_o sequence 1,2,3,0,1.
REQ-044 Reset mid-tag: reset_i asserted asynchronously in TAG_HI -> data_valid_o falls before the next clock edge; after release cap_rdy_o=1, and no stale lo word is emitted.

Source files
------------

// File: rtl/squeeze_out.sv
// Output squeezer: captures a ciphertext word or a key-masked 128-bit tag from
// the permutation state and hands it downstream over a valid/ready handshake.
module squeeze_out #(
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [4:0][63:0]      state_i,
  input  logic [127:0]          key_i,
  input  logic                  cap_block_i,
  input  logic                  cap_tag_i,
  output logic                  cap_rdy_o,
  output logic                  cap_err_o,
  output logic [63:0]           data_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic                  data_kind_o,
  output logic                  data_last_o,
  output logic [CNT_W-1:0]      block_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLOCK  = 2'd1,
    TAG_HI = 2'd2,
    TAG_LO = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        data_q, data_d;
  logic [63:0]        lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               hs;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Status outputs decode straight from the state register so reset clears them at once.
  assign cap_rdy_o    = (state_q == IDLE);
  assign data_valid_o = (state_q != IDLE);
  assign data_kind_o  = (state_q == TAG_HI) || (state_q == TAG_LO);
  assign data_last_o  = (state_q == TAG_LO);
  assign data_o       = data_q;
  assign block_cnt_o  = cnt_q;
  assign cap_err_o    = err_q;
  assign hs           = data_valid_o & data_ready_i;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cap_tag_i) begin
          data_d  = state_i[3] ^ key_i[127:64];
          lo_d    = state_i[4] ^ key_i[63:0];
          state_d = TAG_HI;
          err_d   = cap_block_i;
        end else if (cap_block_i) begin
          data_d  = state_i[0];
          state_d = BLOCK;
        end
      end
      BLOCK: begin
        err_d = cap_block_i | cap_tag_i;
        if (hs) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      TAG_HI: begin
        err_d = cap_block_i | cap_tag_i;
        if (hs) begin
          data_d  = lo_q;
          state_d = TAG_LO;
        end
      end
      TAG_LO: begin
        err_d = cap_block_i | cap_tag_i;
        if (hs) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_squeeze_out.sv
// Directed vector bench for squeeze_out: table of per-cycle vectors plus
// hand-written backpressure, counter-wrap and reset-mid-tag sequences.
module tb_squeeze_out;

  logic              clk;
  logic              reset_i;
  logic [4:0][63:0]  state_i;
  logic [127:0]      key_i;
  logic              cap_block_i, cap_tag_i, data_ready_i;

  logic              cap_rdy_o, cap_err_o, data_valid_o, data_kind_o, data_last_o;
  logic [63:0]       data_o;
  logic [7:0]        block_cnt_o;

  logic              cap_rdy2, cap_err2, valid2, kind2, last2;
  logic [63:0]       data2;
  logic [1:0]        cnt2;

  int unsigned n_vec = 0;
  int unsigned n_fail = 0;

  squeeze_out #(.CNT_W(8)) dut (
    .clock_i(clk), .reset_i(reset_i), .state_i(state_i), .key_i(key_i),
    .cap_block_i(cap_block_i), .cap_tag_i(cap_tag_i), .cap_rdy_o(cap_rdy_o),
    .cap_err_o(cap_err_o), .data_o(data_o), .data_valid_o(data_valid_o),
    .data_ready_i(data_ready_i), .data_kind_o(data_kind_o),
    .data_last_o(data_last_o), .block_cnt_o(block_cnt_o)
  );

  squeeze_out #(.CNT_W(2)) dut2 (
    .clock_i(clk), .reset_i(reset_i), .state_i(state_i), .key_i(key_i),
    .cap_block_i(cap_block_i), .cap_tag_i(cap_tag_i), .cap_rdy_o(cap_rdy2),
    .cap_err_o(cap_err2), .data_o(data2), .data_valid_o(valid2),
    .data_ready_i(data_ready_i), .data_kind_o(kind2),
    .data_last_o(last2), .block_cnt_o(cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic         blk, tag, rdy;
    logic [63:0]  s0, s3, s4;
    logic [127:0] key;
    logic         vld, kind, last;
    logic [63:0]  data;
    logic [7:0]   cnt;
    logic         err, crdy;
  } vec_t;

  localparam logic [63:0]  A  = 64'h0123456789ABCDEF;
  localparam logic [63:0]  B  = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0]  S3 = 64'hFFFF0000FFFF0000;
  localparam logic [63:0]  S4 = 64'h1;
  localparam logic [127:0] K  = 128'hFFFF0000FFFF0000_0000000000000003;

  function automatic vec_t mk(logic blk, logic tag, logic rdy,
                              logic [63:0] s0, logic [63:0] s3, logic [63:0] s4,
                              logic [127:0] key, logic vld, logic kind, logic last,
                              logic [63:0] data, logic [7:0] cnt, logic err, logic crdy);
    vec_t v;
    v.blk = blk; v.tag = tag; v.rdy = rdy;
    v.s0 = s0; v.s3 = s3; v.s4 = s4; v.key = key;
    v.vld = vld; v.kind = kind; v.last = last;
    v.data = data; v.cnt = cnt; v.err = err; v.crdy = crdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic kind,
                         input logic last, input logic [63:0] data,
                         input logic [7:0] cnt, input logic err, input logic crdy);
    chk({tag, ".valid"}, 64'(data_valid_o), 64'(vld));
    chk({tag, ".kind"},  64'(data_kind_o),  64'(kind));
    chk({tag, ".last"},  64'(data_last_o),  64'(last));
    chk({tag, ".data"},  data_o,            data);
    chk({tag, ".cnt"},   64'(block_cnt_o),  64'(cnt));
    chk({tag, ".err"},   64'(cap_err_o),    64'(err));
    chk({tag, ".rdy"},   64'(cap_rdy_o),    64'(crdy));
  endtask

  vec_t vt [11];

  initial begin
    vt[0]  = mk(0,0,1, A,'0,'0,'0,   0,0,0, 64'h0, 8'd0, 0,1);
    vt[1]  = mk(1,0,1, A,'0,'0,'0,   1,0,0, A,     8'd0, 0,0);
    vt[2]  = mk(0,0,1, '0,'0,'0,'0,  0,0,0, A,     8'd1, 0,1);
    vt[3]  = mk(0,1,0, '0,S3,S4,K,   1,1,0, 64'h0, 8'd1, 0,0);
    vt[4]  = mk(1,0,0, '0,'0,'0,'0,  1,1,0, 64'h0, 8'd1, 1,0);
    vt[5]  = mk(0,0,1, '0,'0,'0,'0,  1,1,1, 64'h2, 8'd1, 0,0);
    vt[6]  = mk(0,0,1, '0,'0,'0,'0,  0,0,0, 64'h2, 8'd0, 0,1);
    vt[7]  = mk(1,1,0, A,S3,S4,K,    1,1,0, 64'h0, 8'd0, 1,0);
    vt[8]  = mk(0,0,1, '0,'0,'0,'0,  1,1,1, 64'h2, 8'd0, 0,0);
    vt[9]  = mk(0,0,1, '0,'0,'0,'0,  0,0,0, 64'h2, 8'd0, 0,1);
    vt[10] = mk(0,0,1, '0,'0,'0,'0,  0,0,0, 64'h2, 8'd0, 0,1);

    reset_i = 1'b1; state_i = '0; key_i = '0;
    cap_block_i = 1'b0; cap_tag_i = 1'b0; data_ready_i = 1'b0;
    #12;
    chk_out("reset", 0,0,0, 64'h0, 8'd0, 0,1);
    reset_i = 1'b0;

    for (int i = 0; i < 11; i++) begin
      cap_block_i = vt[i].blk; cap_tag_i = vt[i].tag; data_ready_i = vt[i].rdy;
      state_i = '0;
      state_i[0] = vt[i].s0; state_i[3] = vt[i].s3; state_i[4] = vt[i].s4;
      key_i = vt[i].key;
      step();
      chk_out($sformatf("vec%0d", i), vt[i].vld, vt[i].kind, vt[i].last,
              vt[i].data, vt[i].cnt, vt[i].err, vt[i].crdy);
    end

    // Backpressure: block word held for 5 stalled cycles while state_i churns.
    cap_block_i = 1'b1; data_ready_i = 1'b0; state_i[0] = B;
    step();
    chk_out("bp.cap", 1,0,0, B, 8'd0, 0,0);
    for (int i = 0; i < 5; i++) begin
      cap_block_i = (i == 1);
      state_i[0] = 64'h1111_0000_0000_0000 * 64'(i + 1);
      step();
      chk_out($sformatf("bp.stall%0d", i), 1,0,0, B, 8'd0, (i == 1), 0);
    end
    cap_block_i = 1'b0; data_ready_i = 1'b1;
    step();
    chk_out("bp.hs", 0,0,0, B, 8'd1, 0,1);
    step();
    chk_out("bp.after", 0,0,0, B, 8'd1, 0,1);

    // Counter wrap on the CNT_W=2 instance; capture on the first edge after reset.
    reset_i = 1'b1;
    #2;
    reset_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cap_block_i = 1'b1; data_ready_i = 1'b1; state_i[0] = 64'(k + 100);
      step();
      chk($sformatf("wrap%0d.valid", k), 64'(valid2), 64'd1);
      chk($sformatf("wrap%0d.data", k),  data2, 64'(k + 100));
      cap_block_i = 1'b0;
      step();
      chk($sformatf("wrap%0d.cnt2", k), 64'(cnt2), 64'((k + 1) % 4));
      chk($sformatf("wrap%0d.cnt8", k), 64'(block_cnt_o), 64'(k + 1));
    end

    // Reset asserted in TAG_HI between clock edges.
    cap_tag_i = 1'b1; data_ready_i = 1'b0;
    state_i[3] = S3; state_i[4] = S4; key_i = K;
    step();
    cap_tag_i = 1'b0;
    chk_out("rt.taghi", 1,1,0, 64'h0, 8'd5, 0,0);
    #3;
    reset_i = 1'b1;
    #1;
    chk_out("rt.async", 0,0,0, 64'h0, 8'd0, 0,1);
    #2;
    reset_i = 1'b0;
    data_ready_i = 1'b1;
    step();
    chk_out("rt.nostale", 0,0,0, 64'h0, 8'd0, 0,1);
    step();
    chk_out("rt.nostale2", 0,0,0, 64'h0, 8'd0, 0,1);
    cap_block_i = 1'b1; state_i[0] = A;
    step();
    cap_block_i = 1'b0;
    chk_out("rt.recap", 1,0,0, A, 8'd0, 0,0);
    step();
    chk_out("rt.done", 0,0,0, A, 8'd1, 0,1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
